mdr_byte_read_seq: RTL and testbench
====================================

// Module: mdr_byte_read_seq
//
// PURPOSE
// Sequencer that turns CPU read requests into 8-bit memory reads and drives the
// strobes of the downstream MDR byte-to-word shift register. Sits between the
// bus/control unit and the MDR word assembler. Fetches one byte (zero-extended)
// or two bytes (little-endian word). Pulses done once the assembled word is stable.
//
// PARAMETERS
// ADDR_W   16  width of request and memory address
// MEM_LAT  1   cycles from mem_rd pulse to byte valid on MDR; legal range 1..15
//
// PORTS
// clk            in   1       system clock
// rst            in   1       synchronous, active-high reset
// req_valid      in   1       read request present
// req_ready      out  1       sequencer can accept a request
// req_addr       in   ADDR_W  byte address, sampled on accept
// req_word       in   1       1 = 16-bit word read, 0 = byte read; sampled on accept
// mem_rd         out  1       one-cycle memory read strobe
// mem_addr       out  ADDR_W  memory byte address, valid when mem_rd=1
// mem_wait       in   1       memory not ready; stretches the data phase
// byte_low_we    out  1       load MDR byte into word[7:0]
// byte_high_we   out  1       load MDR byte into word[15:8]
// byte_high_rst  out  1       clear word[15:8] (zero-extend byte reads)
// done           out  1       one-cycle pulse; assembled word valid this cycle
// err            out  1       one-cycle pulse; request rejected (see CONFIGURATION)
//
// BEHAVIOUR
// - States: IDLE, RD_LO, WT_LO, RD_HI, WT_HI, DONE.
// - Reset: state=IDLE. All strobes, done and err are 0. Latency counter is 0.
//   req_ready is forced 0 in any cycle with rst=1.
// - req_ready=1 only in IDLE. Accept = req_valid & req_ready. On accept, latch
//   addr and word, then go to RD_LO.
// - RD_LO: mem_rd=1, mem_addr=addr. Load counter with MEM_LAT-1, go to WT_LO.
// - WT_LO: decrement the counter each cycle mem_wait=0. In the cycle counter==0 and
//   mem_wait=0, assert byte_low_we. For a byte read, also assert byte_high_rst
//   and go to DONE. For a word read, go to RD_HI. If mem_wait=1, hold with no strobe.
// - RD_HI: mem_rd=1, mem_addr=addr+1 (mod 2^ADDR_W, wraps 0xFFFF->0x0000).
//   Go to WT_HI.
// - WT_HI: same as WT_LO, but asserts byte_high_we only, then goes to DONE.
// - DONE: done=1 for one cycle, then IDLE. No request is accepted in DONE.
// - Latency (MEM_LAT=1, no wait), counted from the accept cycle c0:
//   byte read: mem_rd c1, byte_low_we c2, done c3.
//   word read: mem_rd c1/c3, byte_low_we c2, byte_high_we c4, done c5.
//   Each mem_wait cycle in a data phase adds one cycle.
// - At most one of byte_low_we/byte_high_we is high per cycle. mem_rd is never
//   high in the same cycle as a we strobe.
// - mem_addr is held at its last value when mem_rd=0.
// - Reset mid-operation: abort the sequence. No further strobes and no done.
//   IDLE in the cycle after rst falls.
//
// CONFIGURATION
// MISALIGN_TRAP_EN defined: an accepted word read with addr[0]=1 goes IDLE->DONE
//   path replaced by err=1 for one cycle (c1). No mem_rd, no strobes, no done.
//   req_ready=1 again at c2.
// MISALIGN_TRAP_EN undefined: odd word reads proceed normally (addr, addr+1).
//   err is tied to 0.
//
// TESTING
// 1 Byte read 0x0010, MEM_LAT=1, mem returns 0xAB -> mem_rd/addr 0x0010 c1;
//   byte_low_we+byte_high_rst c2; done c3; model word=0x00AB.
// 2 Word read 0x0020, mem 0x0020=0xAB, 0x0021=0xCD -> mem_rd c1(0x0020), c3(0x0021);
//   low_we c2; high_we c4; done c5; word=0xCDAB.
// 3 Word read, mem_wait=1 for 2 cycles in WT_LO -> byte_low_we moves c2->c4;
//   done at c7; no strobe while waiting.
// 4 Word read 0xFFFF, macro off -> second mem_addr=0x0000. Macro on: word read
//   0x0021 -> err c1, no mem_rd, req_ready=1 c2.
// 5 rst=1 at c3 of a word read -> no byte_high_we, no done; req_ready=1 the
//   cycle after rst falls; next request completes normally.
// 6 MEM_LAT=3, req_valid held high for two byte reads -> first done at c5;
//   second accept at c6; strobe gap matches MEM_LAT.

Source files
------------

// File: rtl/mdr_byte_read_seq.sv
// Read sequencer: one byte or a little-endian word from 8-bit memory into the MDR shift register.
// Optional MISALIGN_TRAP_EN rejects odd-address word reads with a one-cycle err pulse.
module mdr_byte_read_seq #(
  parameter int ADDR_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_word,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_wait,
  output logic              byte_low_we,
  output logic              byte_high_we,
  output logic              byte_high_rst,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, RD_LO, WT_LO, RD_HI, WT_HI, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q, maddr_q;
  logic              word_q;
  logic [3:0]        cnt_q, cnt_nx;
  logic              trap_q, trap_nx;
  logic              accept, misalign;
  logic              rd_c, lo_c, hi_c, hrst_c, done_c;

  assign req_ready = (state == IDLE) & ~rst;
  assign accept    = req_valid & req_ready;

`ifdef MISALIGN_TRAP_EN
  assign misalign = req_word & req_addr[0];
  assign err      = (state == DONE) & trap_q & ~rst;
`else
  assign misalign = 1'b0;
  assign err      = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt_q;
    trap_nx  = trap_q;
    mem_addr = maddr_q;
    rd_c     = 1'b0;
    lo_c     = 1'b0;
    hi_c     = 1'b0;
    hrst_c   = 1'b0;
    done_c   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          trap_nx  = misalign;
          state_nx = misalign ? DONE : RD_LO;
        end
      end
      RD_LO: begin
        rd_c     = 1'b1;
        mem_addr = addr_q;
        cnt_nx   = CNT_INIT;
        state_nx = WT_LO;
      end
      WT_LO: begin
        if (!mem_wait) begin
          if (cnt_q == 4'd0) begin
            lo_c     = 1'b1;
            hrst_c   = ~word_q;
            state_nx = word_q ? RD_HI : DONE;
          end else begin
            cnt_nx = cnt_q - 4'd1;
          end
        end
      end
      RD_HI: begin
        rd_c     = 1'b1;
        mem_addr = addr_q + ADDR_W'(1);
        cnt_nx   = CNT_INIT;
        state_nx = WT_HI;
      end
      WT_HI: begin
        if (!mem_wait) begin
          if (cnt_q == 4'd0) begin
            hi_c     = 1'b1;
            state_nx = DONE;
          end else begin
            cnt_nx = cnt_q - 4'd1;
          end
        end
      end
      DONE: begin
        // a trapped request reuses DONE to emit err instead of done
        done_c   = ~trap_q;
        trap_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // reset cycle suppresses every strobe even though state still holds the old value
  assign mem_rd        = rd_c   & ~rst;
  assign byte_low_we   = lo_c   & ~rst;
  assign byte_high_we  = hi_c   & ~rst;
  assign byte_high_rst = hrst_c & ~rst;
  assign done          = done_c & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt_q   <= 4'd0;
      trap_q  <= 1'b0;
      addr_q  <= '0;
      word_q  <= 1'b0;
      maddr_q <= '0;
    end else begin
      state   <= state_nx;
      cnt_q   <= cnt_nx;
      trap_q  <= trap_nx;
      maddr_q <= mem_addr;
      if (accept) begin
        addr_q <= req_addr;
        word_q <= req_word;
      end
    end
  end

endmodule

// File: tb/tb_mdr_byte_read_seq.sv
// Bench for mdr_byte_read_seq: cycle table for MEM_LAT=1 plus hand sequences for edge cases.
module tb_mdr_byte_read_seq;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_word, mem_wait;
  logic [15:0] req_addr;
  logic        req_ready, mem_rd, byte_low_we, byte_high_we, byte_high_rst, done, err;
  logic [15:0] mem_addr;

  logic        vld3, word3;
  logic [15:0] addr3, maddr3;
  logic        rdy3, rd3, lo3, hi3, hrst3, done3, err3;

  int checks = 0;
  int errors = 0;
  int bad_inv = 0;

  always #5 clk = ~clk;

  mdr_byte_read_seq #(.ADDR_W(16), .MEM_LAT(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_word(req_word), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_wait(mem_wait), .byte_low_we(byte_low_we), .byte_high_we(byte_high_we),
    .byte_high_rst(byte_high_rst), .done(done), .err(err));

  mdr_byte_read_seq #(.ADDR_W(16), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(vld3), .req_ready(rdy3),
    .req_addr(addr3), .req_word(word3), .mem_rd(rd3), .mem_addr(maddr3),
    .mem_wait(1'b0), .byte_low_we(lo3), .byte_high_we(hi3),
    .byte_high_rst(hrst3), .done(done3), .err(err3));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] memb(input logic [15:0] a);
    case (a)
      16'h0010: memb = 8'hAB;
      16'h0020: memb = 8'hAB;
      16'h0021: memb = 8'hCD;
      default:  memb = a[7:0] ^ 8'h5A;
    endcase
  endfunction

  // MDR word assembler model fed by the strobes of the MEM_LAT=1 instance
  logic [15:0] last_rd_addr, mdr_word, acc_addr;
  logic        acc_word;
  always @(negedge clk) begin
    if ((byte_low_we && byte_high_we) || (mem_rd && (byte_low_we || byte_high_we))) bad_inv++;
    if ((lo3 && hi3) || (rd3 && (lo3 || hi3))) bad_inv++;
    if (req_valid && req_ready) begin
      acc_addr = req_addr;
      acc_word = req_word;
    end
    if (mem_rd) last_rd_addr = mem_addr;
    if (byte_low_we) mdr_word[7:0] = memb(last_rd_addr);
    if (byte_high_rst) mdr_word[15:8] = 8'h00;
    if (byte_high_we) mdr_word[15:8] = memb(last_rd_addr);
    if (done)
      chk("word_at_done", 32'(mdr_word),
          32'(acc_word ? {memb(acc_addr + 16'd1), memb(acc_addr)} : {8'h00, memb(acc_addr)}));
  end

  typedef struct {
    logic        rst, vld;
    logic [15:0] addr;
    logic        word, wt;
    logic        rdy, rd;
    logic [15:0] maddr;
    logic        lo, hi, hrst, dn;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic r, v, input logic [15:0] a, input logic w, wt,
                              input logic rdy, rd, input logic [15:0] ma,
                              input logic lo, hi, hrst, dn);
    vec_t t;
    t.rst = r; t.vld = v; t.addr = a; t.word = w; t.wt = wt;
    t.rdy = rdy; t.rd = rd; t.maddr = ma; t.lo = lo; t.hi = hi; t.hrst = hrst; t.dn = dn;
    tbl.push_back(t);
  endfunction

  task automatic run_byte(input string nm, input logic [15:0] a);
    int got;
    got = 0;
    req_valid = 1'b1; req_addr = a; req_word = 1'b0;
    @(negedge clk);
    chk({nm, "_ready"}, 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done) begin
        got = k;
        break;
      end
      tick();
    end
    chk({nm, "_done_cycle"}, 32'(got), 32'd3);
    tick();
  endtask

  initial begin
    int lo_c1, lo_c2, dn_c1, acc2, rd_c1, n_acc, seen;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_word = 1'b0; mem_wait = 1'b0;
    vld3 = 1'b0; addr3 = '0; word3 = 1'b0;
    mdr_word = '0; last_rd_addr = '0; acc_addr = '0; acc_word = 1'b0;
    #1;
    tick();

    //   rst vld addr      wd wt | rdy rd maddr     lo hi hr dn
    add(1, 0, 16'h0000, 0, 0,   0, 0, 16'h0000, 0, 0, 0, 0);
    add(0, 0, 16'h0000, 0, 0,   1, 0, 16'h0000, 0, 0, 0, 0);
    add(0, 1, 16'h0010, 0, 0,   1, 0, 16'h0000, 0, 0, 0, 0);
    add(0, 0, 16'h0000, 0, 0,   0, 1, 16'h0010, 0, 0, 0, 0);
    add(0, 0, 16'h0000, 0, 0,   0, 0, 16'h0010, 1, 0, 1, 0);
    add(0, 0, 16'h0000, 0, 0,   0, 0, 16'h0010, 0, 0, 0, 1);
    add(0, 0, 16'h0000, 0, 0,   1, 0, 16'h0010, 0, 0, 0, 0);
    add(0, 1, 16'h0020, 1, 0,   1, 0, 16'h0010, 0, 0, 0, 0);
    add(0, 0, 16'h0000, 0, 0,   0, 1, 16'h0020, 0, 0, 0, 0);
    add(0, 0, 16'h0000, 0, 0,   0, 0, 16'h0020, 1, 0, 0, 0);
    add(0, 0, 16'h0000, 0, 0,   0, 1, 16'h0021, 0, 0, 0, 0);
    add(0, 0, 16'h0000, 0, 0,   0, 0, 16'h0021, 0, 1, 0, 0);
    add(0, 0, 16'h0000, 0, 0,   0, 0, 16'h0021, 0, 0, 0, 1);
    add(0, 0, 16'h0000, 0, 0,   1, 0, 16'h0021, 0, 0, 0, 0);
    add(0, 1, 16'h0030, 1, 0,   1, 0, 16'h0021, 0, 0, 0, 0);
    add(0, 0, 16'h0000, 0, 0,   0, 1, 16'h0030, 0, 0, 0, 0);
    add(0, 0, 16'h0000, 0, 1,   0, 0, 16'h0030, 0, 0, 0, 0);
    add(0, 0, 16'h0000, 0, 1,   0, 0, 16'h0030, 0, 0, 0, 0);
    add(0, 0, 16'h0000, 0, 0,   0, 0, 16'h0030, 1, 0, 0, 0);
    add(0, 0, 16'h0000, 0, 0,   0, 1, 16'h0031, 0, 0, 0, 0);
    add(0, 0, 16'h0000, 0, 0,   0, 0, 16'h0031, 0, 1, 0, 0);
    add(0, 1, 16'h0040, 0, 0,   0, 0, 16'h0031, 0, 0, 0, 1);
    add(0, 1, 16'h0040, 0, 0,   1, 0, 16'h0031, 0, 0, 0, 0);
    add(0, 0, 16'h0000, 0, 0,   0, 1, 16'h0040, 0, 0, 0, 0);
    add(0, 0, 16'h0000, 0, 0,   0, 0, 16'h0040, 1, 0, 1, 0);
    add(0, 0, 16'h0000, 0, 0,   0, 0, 16'h0040, 0, 0, 0, 1);
    add(0, 0, 16'h0000, 0, 0,   1, 0, 16'h0040, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; req_valid = tbl[i].vld; req_addr = tbl[i].addr;
      req_word = tbl[i].word; mem_wait = tbl[i].wt;
      @(negedge clk);
      chk($sformatf("row%0d_ctl", i),
          32'({req_ready, mem_rd, byte_low_we, byte_high_we, byte_high_rst, done, err}),
          32'({tbl[i].rdy, tbl[i].rd, tbl[i].lo, tbl[i].hi, tbl[i].hrst, tbl[i].dn, 1'b0}));
      chk($sformatf("row%0d_maddr", i), 32'(mem_addr), 32'(tbl[i].maddr));
      tick();
    end
    rst = 1'b0; req_valid = 1'b0; mem_wait = 1'b0;

`ifdef MISALIGN_TRAP_EN
    req_valid = 1'b1; req_addr = 16'h0021; req_word = 1'b1;
    @(negedge clk);
    chk("trap_accept", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("trap_c1", 32'({err, mem_rd, done, req_ready}), 32'b1000);
    tick();
    @(negedge clk);
    chk("trap_c2", 32'({err, mem_rd, done, req_ready}), 32'b0001);
    tick();
`else
    req_valid = 1'b1; req_addr = 16'hFFFF; req_word = 1'b1;
    @(negedge clk);
    chk("wrap_accept", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("wrap_rd_lo", 32'({mem_rd, mem_addr}), {15'd0, 1'b1, 16'hFFFF});
    tick();
    tick();
    @(negedge clk);
    chk("wrap_rd_hi", 32'({mem_rd, mem_addr}), {15'd0, 1'b1, 16'h0000});
    tick();
    @(negedge clk);
    chk("wrap_hi_we", 32'(byte_high_we), 32'd1);
    tick();
    @(negedge clk);
    chk("wrap_done", 32'({done, err}), 32'b10);
    tick();
`endif

    // reset lands on c3 of a word read
    req_valid = 1'b1; req_addr = 16'h0050; req_word = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("abort_c2_lo", 32'(byte_low_we), 32'd1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("abort_c3", 32'({mem_rd, byte_high_we, done, req_ready}), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(req_ready), 32'd1);
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (byte_high_we || done || mem_rd) seen++;
      tick();
    end
    chk("abort_quiet", 32'(seen), 32'd0);
    run_byte("after_abort", 16'h0060);

    // MEM_LAT=3 with req_valid held for two byte reads
    vld3 = 1'b1; addr3 = 16'h0070; word3 = 1'b0;
    lo_c1 = -1; lo_c2 = -1; dn_c1 = -1; acc2 = -1; rd_c1 = -1; n_acc = 0;
    for (int n = 0; n <= 20; n++) begin
      @(negedge clk);
      if (vld3 && rdy3) begin
        n_acc++;
        if (n_acc == 2) acc2 = n;
      end
      if (rd3 && rd_c1 < 0 && maddr3 == 16'h0070) rd_c1 = n;
      if (lo3) begin
        if (lo_c1 < 0) lo_c1 = n; else if (lo_c2 < 0) lo_c2 = n;
      end
      if (done3 && dn_c1 < 0) dn_c1 = n;
      tick();
      if (n_acc == 2) vld3 = 1'b0;
    end
    chk("lat3_rd_cycle", 32'(rd_c1), 32'd1);
    chk("lat3_lo_cycle", 32'(lo_c1), 32'd4);
    chk("lat3_done_cycle", 32'(dn_c1), 32'd5);
    chk("lat3_second_accept", 32'(acc2), 32'd6);
    chk("lat3_strobe_gap", 32'(lo_c2 - lo_c1), 32'd6);
    chk("strobe_exclusion", 32'(bad_inv), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
